ula_exec_stage: RTL and testbench
=================================

ULA_EXEC_STAGE -- requirements
Module: ula_exec_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  upstream (decode) presents an operation.
REQ-004 in_ready  output  1  stage accepts the operation this cycle.
REQ-005 in_op  input  4  ALU opcode: 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV, 0101 MOD, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT, 1010 NOR, 1011 NAND, 1100 XNOR.
REQ-006 in_a / in_b  input  8 each  operand1 / operand2.
REQ-007 in_dest  input  3  destination register tag, carried unmodified.
REQ-008 out_valid  output  1  result available to writeback.
REQ-009 out_ready  input  1  writeback consumes the result.
REQ-010 out_result  output  8  registered ALU result.
REQ-011 out_flags  output  4  registered flags {V,C,S,Z}, bits [3:0] = V,C,S,Z.
REQ-012 out_dest  output  3  tag of the result.
REQ-013 out_fault  output  1  operation was illegal (bad opcode or DIV/MOD by zero).
REQ-014 flags_q  output  4  architectural flags register.
REQ-015 op_count  output  16  completed (handshaken) results, wrapping.
REQ-016 fault_count  output  8  faulted results, saturating at 255.

Function
REQ-017 Two registered stages: S1 (operand register: op, a, b, dest, valid) and S2 (output register); a transfer occurs on valid&&ready at a rising edge.
REQ-018 Advance rule: s2_free = !out_valid || out_ready; in_ready = !s1_valid || s2_free; S1 moves to S2 only when s1_valid && s2_free.
REQ-019 Latency: operation accepted at edge N is presented on out_* after edge N+1 when no stall; throughput one operation per cycle.
REQ-020 S2 captures combinational ALU outputs driven from S1 contents; out_* held stable while out_valid && !out_ready.
REQ-021 Fault: opcode 0000 or 1101-1111, or opcode 0100/0101 with b == 0 -> out_result = 8'h00, out_flags = 4'b0000, out_fault = 1.
REQ-022 flags_q loads out_flags on output handshake only when out_fault = 0; faulted results leave flags_q unchanged.
REQ-023 op_count increments by 1 on every output handshake (including faults), 16'hFFFF wraps to 0.
REQ-024 fault_count increments on handshake with out_fault = 1, holds at 8'hFF.
REQ-025 Simultaneous accept and drain in the same cycle with both stages full SHALL lose no operation and preserve order.
REQ-026 Operations leave strictly in acceptance order; in_dest travels with its operands.
REQ-027 Inputs are ignored (no state change) when in_valid = 0 or in_ready = 0.

Reset
REQ-028 On rst_n low, immediately: s1_valid = 0, out_valid = 0, out_result = 0, out_flags = 0, out_dest = 0, out_fault = 0, flags_q = 0, op_count = 0, fault_count = 0.
REQ-029 in_ready = 1 during and after reset; in-flight operations are discarded, not completed.
REQ-030 Reset release is synchronous-safe: first acceptance possible at first rising edge with rst_n high.

Structure
REQ-031 Shared package ula_pkg holds opcode constants, flag bit indices (FLAG_Z=0, FLAG_S=1, FLAG_C=2, FLAG_V=3), data width 8, tag width 3.
REQ-032 One sub-module: the existing combinational ULA, instantiated once between S1 and S2; fault detection lives in this block, not in ULA.

Verification
REQ-033 ADD a=8'h7F b=8'h01 -> after 2 edges out_result 8'h80, out_flags 4'b1010, out_fault 0; after handshake flags_q 4'b1010, op_count 1.
REQ-034 SUB a=8'h05 b=8'h05 then AND a=8'hF0 b=8'h0F back-to-back -> results 8'h00 flags 4'b0001 then 8'h00 flags 4'b0001, one per cycle.
REQ-035 out_ready low 4 cycles, in_valid high with 3 ops -> 2 accepted, in_ready low, then all 3 emerge in order with correct in_dest tags.
REQ-036 op 4'b0000 then DIV a=9 b=0 -> both out_fault 1, result 0, flags_q unchanged, fault_count 2.
REQ-037 rst_n pulsed low with S1 and S2 full -> out_valid 0 immediately, all counters 0, in_ready 1, no stale result appears after release.
REQ-038 256 faults accepted -> fault_count stops at 8'hFF; 65536 handshakes -> op_count wraps to 0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA execute stage: widths, opcodes, flag bit
// positions and the illegal-operation check.
package ula_pkg;

    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOD  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_XNOR = 4'b1100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Unknown opcodes and division/modulo by zero are reported instead of computed.
    function automatic logic op_is_fault(input logic [3:0] op, input logic [DATA_W-1:0] b);
        logic fault;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_NOR, OP_NAND, OP_XNOR: fault = 1'b0;
            OP_DIV, OP_MOD:                   fault = (b == 8'h00);
            default:                          fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/ula_exec_stage_ula.sv
// Combinational ULA: unsigned arithmetic and bitwise logic with {V,C,S,Z} flags.
// C is carry for ADD, borrow for SUB and "high byte non-zero" for MUL.
module ula_exec_stage_ula
    import ula_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   res_s;
    logic                carry_s;
    logic                ovf_s;

    // Opcode decode and flag generation.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b};
        diff_s  = {1'b0, a} - {1'b0, b};
        prod_s  = {8'h00, a} * {8'h00, b};
        res_s   = 8'h00;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_ADD: begin
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
                ovf_s   = (a[7] == b[7]) && (sum_s[7] != a[7]);
            end
            OP_SUB: begin
                res_s   = diff_s[DATA_W-1:0];
                carry_s = diff_s[DATA_W];
                ovf_s   = (a[7] != b[7]) && (diff_s[7] != a[7]);
            end
            OP_MUL: begin
                res_s   = prod_s[DATA_W-1:0];
                carry_s = |prod_s[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (b != 8'h00) begin
                    res_s = a / b;
                end else begin
                    res_s = 8'h00;
                end
            end
            OP_MOD: begin
                if (b != 8'h00) begin
                    res_s = a % b;
                end else begin
                    res_s = 8'h00;
                end
            end
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_XOR:  res_s = a ^ b;
            OP_NOT:  res_s = ~a;
            OP_NOR:  res_s = ~(a | b);
            OP_NAND: res_s = ~(a & b);
            OP_XNOR: res_s = ~(a ^ b);
            default: res_s = 8'h00;
        endcase
        result         = res_s;
        flags          = 4'b0000;
        flags[FLAG_V]  = ovf_s;
        flags[FLAG_C]  = carry_s;
        flags[FLAG_S]  = res_s[7];
        flags[FLAG_Z]  = (res_s == 8'h00);
    end

endmodule

// File: rtl/ula_exec_stage.sv
// Two-stage execute pipeline: operand register S1 feeding the ULA, output
// register S2, plus architectural flags and completion/fault counters.
module ula_exec_stage
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [TAG_W-1:0]  out_dest,
    output logic              out_fault,
    output logic [3:0]        flags_q,
    output logic [15:0]       op_count,
    output logic [7:0]        fault_count
);

    logic              s1_valid_r;
    logic [3:0]        s1_op_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;
    logic [TAG_W-1:0]  s1_dest_r;

    logic              s2_free_s;
    logic              accept_s;
    logic              advance_s;
    logic              out_hs_s;
    logic              fault_s;
    logic [DATA_W-1:0] alu_result_s;
    logic [3:0]        alu_flags_s;

    assign s2_free_s = !out_valid || out_ready;
    assign in_ready  = !s1_valid_r || s2_free_s;
    assign accept_s  = in_valid && in_ready;
    assign advance_s = s1_valid_r && s2_free_s;
    assign out_hs_s  = out_valid && out_ready;
    assign fault_s   = op_is_fault(s1_op_r, s1_b_r);

    ula_exec_stage_ula u_ula (
        .op     (s1_op_r),
        .a      (s1_a_r),
        .b      (s1_b_r),
        .result (alu_result_s),
        .flags  (alu_flags_s)
    );

    // S1 operand register: a new accept takes priority over emptying into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 4'b0000;
            s1_a_r     <= 8'h00;
            s1_b_r     <= 8'h00;
            s1_dest_r  <= 3'b000;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= in_op;
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_dest_r  <= in_dest;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 output register; payload only changes when a new operation arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= 8'h00;
            out_flags  <= 4'b0000;
            out_dest   <= 3'b000;
            out_fault  <= 1'b0;
        end else if (advance_s) begin
            out_valid  <= 1'b1;
            out_result <= fault_s ? 8'h00 : alu_result_s;
            out_flags  <= fault_s ? 4'b0000 : alu_flags_s;
            out_dest   <= s1_dest_r;
            out_fault  <= fault_s;
        end else if (out_hs_s) begin
            out_valid  <= 1'b0;
        end
    end

    // Architectural state committed at output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= 4'b0000;
            op_count    <= 16'h0000;
            fault_count <= 8'h00;
        end else if (out_hs_s) begin
            op_count <= op_count + 16'h0001;
            if (out_fault) begin
                if (fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'h01;
                end
            end else begin
                flags_q <= out_flags;
            end
        end
    end

endmodule

// File: tb/tb_ula_exec_stage.sv
// Bench for ula_exec_stage: a 2-deep in-order queue model with a reference
// ALU computed in integer arithmetic, checked every cycle, plus directed cases.
module tb_ula_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_dest;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_dest;
    logic       out_fault;
    logic [3:0] flags_q;
    logic [15:0] op_count;
    logic [7:0] fault_count;

    ula_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_dest(out_dest), .out_fault(out_fault),
        .flags_q(flags_q), .op_count(op_count), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        int         a;
        int         b;
        logic [2:0] dest;
        int         t;
    } item_t;

    item_t       q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  m_flags = 4'b0000;
    logic [15:0] m_ops = 16'h0000;
    logic [7:0]  m_faults = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table: flags packed {V,C,S,Z}.
    function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                    output int r, output logic [3:0] f, output logic flt);
        int full;
        int sa;
        int sb;
        logic c;
        logic v;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        full = 0; c = 1'b0; v = 1'b0; flt = 1'b0;
        case (op)
            4'd1:  begin full = a + b; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd2:  begin full = a - b; c = (a < b);      v = (sa - sb > 127) || (sa - sb < -128); end
            4'd3:  begin full = a * b; c = (full > 255); end
            4'd4:  if (b == 0) flt = 1'b1; else full = a / b;
            4'd5:  if (b == 0) flt = 1'b1; else full = a % b;
            4'd6:  full = a & b;
            4'd7:  full = a | b;
            4'd8:  full = a ^ b;
            4'd9:  full = ~a;
            4'd10: full = ~(a | b);
            4'd11: full = ~(a & b);
            4'd12: full = ~(a ^ b);
            default: flt = 1'b1;
        endcase
        r = full & 255;
        if (flt) begin
            r = 0;
            f = 4'b0000;
        end else begin
            f = {v, c, (r >= 128), (r == 0)};
        end
    endfunction

    // One clock cycle: drive, compare against the model before the edge, then advance the model.
    task automatic step(input logic iv, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] dest, input logic ordy,
                        output logic acc);
        logic       exp_ready;
        logic       exp_ov;
        logic       hs;
        int         r;
        logic [3:0] f;
        logic       flt;
        item_t      it;
        in_valid = iv; in_op = op; in_a = a; in_b = b; in_dest = dest; out_ready = ordy;
        @(negedge clk);
        exp_ready = (q.size() < 2) || ordy;
        exp_ov    = (q.size() > 0) && (cyc >= q[0].t + 2);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, exp_ov);
        chk("flags_q", flags_q, m_flags);
        chk("op_count", op_count, m_ops);
        chk("fault_count", fault_count, m_faults);
        r = 0; f = 4'b0000; flt = 1'b0;
        if (exp_ov) begin
            ref_alu(q[0].op, q[0].a, q[0].b, r, f, flt);
            chk("out_result", out_result, r);
            chk("out_flags", out_flags, f);
            chk("out_dest", out_dest, q[0].dest);
            chk("out_fault", out_fault, flt);
        end
        acc = iv && exp_ready;
        hs  = exp_ov && ordy;
        @(posedge clk);
        #1;
        if (hs) begin
            void'(q.pop_front());
            m_ops++;
            if (flt) begin
                if (m_faults != 8'hFF) m_faults++;
            end else begin
                m_flags = f;
            end
        end
        if (acc) begin
            it.op = op; it.a = a; it.b = b; it.dest = dest; it.t = cyc;
            q.push_back(it);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    endtask

    logic [3:0] st_op[3]   = '{4'd1, 4'd2, 4'd8};
    logic [7:0] st_a[3]    = '{8'd10, 8'd50, 8'hAA};
    logic [7:0] st_b[3]    = '{8'd20, 8'd8, 8'h55};
    logic [2:0] st_dest[3] = '{3'd1, 3'd2, 3'd3};

    initial begin
        int         r;
        logic [3:0] f;
        logic       flt;
        logic       acc;
        int         k;

        // Pin the reference model on hand-computed cases.
        ref_alu(4'd1, 8'h7F, 8'h01, r, f, flt);
        chk("pin_add", {r[7:0], f, flt}, {8'h80, 4'b1010, 1'b0});
        ref_alu(4'd2, 8'h05, 8'h05, r, f, flt);
        chk("pin_sub", {r[7:0], f, flt}, {8'h00, 4'b0001, 1'b0});
        ref_alu(4'd6, 8'hF0, 8'h0F, r, f, flt);
        chk("pin_and", {r[7:0], f, flt}, {8'h00, 4'b0001, 1'b0});
        ref_alu(4'd4, 8'd9, 8'd0, r, f, flt);
        chk("pin_div0", {r[7:0], f, flt}, {8'h00, 4'b0000, 1'b1});
        ref_alu(4'd2, 8'd3, 8'd5, r, f, flt);
        chk("pin_borrow", {r[7:0], f, flt}, {8'hFE, 4'b0110, 1'b0});

        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = 8'h00; in_b = 8'h00;
        in_dest = 3'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", {out_result, out_flags, out_dest, out_fault}, 16'h0000);
        chk("rst_counters", {flags_q, op_count, fault_count}, 28'h0);
        rst_n = 1'b1;

        // ADD 7F+01 with latency and handshake.
        step(1'b1, 4'd1, 8'h7F, 8'h01, 3'd5, 1'b0, acc);
        step(1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
        chk("add_lit", {out_valid, out_result, out_flags, out_fault}, {1'b1, 8'h80, 4'b1010, 1'b0});
        step(1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        chk("add_commit", {flags_q, op_count}, {4'b1010, 16'd1});

        // SUB then AND back-to-back.
        step(1'b1, 4'd2, 8'h05, 8'h05, 3'd1, 1'b1, acc);
        step(1'b1, 4'd6, 8'hF0, 8'h0F, 3'd2, 1'b1, acc);
        chk("sub_lit", {out_valid, out_result, out_flags, out_dest}, {1'b1, 8'h00, 4'b0001, 3'd1});
        step(1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        chk("and_lit", {out_valid, out_result, out_flags, out_dest}, {1'b1, 8'h00, 4'b0001, 3'd2});
        idle(2);

        // Illegal opcode then DIV by zero: flags_q keeps the AND result.
        step(1'b1, 4'd0, 8'd1, 8'd2, 3'd3, 1'b1, acc);
        step(1'b1, 4'd4, 8'd9, 8'd0, 3'd4, 1'b1, acc);
        idle(3);
        chk("fault_lit", {flags_q, fault_count, op_count}, {4'b0001, 8'd2, 16'd5});

        // Output stalled 4 cycles while three ops are offered.
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, st_op[k], st_a[k], st_b[k], st_dest[k], 1'b0, acc);
            if (acc) k++;
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(k < 3, st_op[k % 3], st_a[k % 3], st_b[k % 3], st_dest[k % 3], 1'b1, acc);
            if (acc) k++;
        end
        chk("stall_drained", {k[7:0], op_count}, {8'd3, 16'd8});

        // Randomized traffic with stalls, illegal ops and zero divisors.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom), rb,
                 3'($urandom), $urandom_range(0, 9) < 7, acc);
        end
        idle(3);

        // Saturation of fault_count.
        for (int i = 0; i < 300; i++) step(1'b1, 4'hF, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, acc);
        idle(3);
        chk("fault_sat", fault_count, 8'hFF);

        // Reset with both stages full.
        step(1'b1, 4'd1, 8'd1, 8'd2, 3'd6, 1'b0, acc);
        step(1'b1, 4'd1, 8'd3, 8'd4, 3'd7, 1'b0, acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_counters", {flags_q, op_count, fault_count, out_result}, 36'h0);
        q.delete();
        m_flags = 4'b0000; m_ops = 16'h0000; m_faults = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // op_count wrap: 65538 handshakes from a fresh count.
        for (int i = 0; i < 65540; i++) step(1'b1, 4'd1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, acc);
        chk("op_wrap", op_count, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
